seq_mult: RTL and testbench

Parametrised iterative shift-add integer multiplier. It is the sequential successor to the combinational 8x8 soft multiplier used in the top level. Operands are accepted with a valid/ready handshake and retired at one multiplier bit per clock. The product is held under output backpressure. Optional signed (two's-complement) mode is selectable per operation. The block sits between operand producers and consumers in the `clk_100m_o` domain behind the rPLL.

---
 rtl/seq_mult.sv | 174 +++++++++++++++++
 tb/tb_seq_mult.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier retiring one multiplier bit per clock, with valid/ready on both sides.
// Optional per-operation two's-complement mode is compiled in by defining MULT_SIGNED_EN.
module seq_mult #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [A_WIDTH-1:0]           a_i,
    input  logic [B_WIDTH-1:0]           b_i,
    input  logic                         signed_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [A_WIDTH+B_WIDTH-1:0]   product_o
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int CNT_W   = $clog2(B_WIDTH + 1);

    localparam logic [P_WIDTH-1:0] P_ZERO = {P_WIDTH{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(B_WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [P_WIDTH-1:0]   mcand_r;
    logic [B_WIDTH-1:0]   mplier_r;
    logic [P_WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 neg_r;
    logic                 ready_r;
    logic                 valid_r;
    logic [P_WIDTH-1:0]   product_r;

    logic                 signed_sel_s;
    logic [A_WIDTH-1:0]   a_mag_s;
    logic [B_WIDTH-1:0]   b_mag_s;
    logic                 neg_s;
    logic [P_WIDTH-1:0]   partial_s;
    logic [P_WIDTH-1:0]   acc_next_s;
    logic [P_WIDTH-1:0]   result_s;

`ifdef MULT_SIGNED_EN
    function automatic logic [A_WIDTH-1:0] abs_a(input logic [A_WIDTH-1:0] v, input logic sgn);
        logic [A_WIDTH-1:0] r;
        if (sgn && v[A_WIDTH-1]) begin
            r = ~v + {{(A_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [B_WIDTH-1:0] abs_b(input logic [B_WIDTH-1:0] v, input logic sgn);
        logic [B_WIDTH-1:0] r;
        if (sgn && v[B_WIDTH-1]) begin
            r = ~v + {{(B_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [P_WIDTH-1:0] neg_p(input logic [P_WIDTH-1:0] v);
        return ~v + {{(P_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign signed_sel_s = signed_i;
`else
    // Sign select is tied off; the mask only keeps the unused port visible to lint.
    assign signed_sel_s = signed_i & 1'b0;
`endif

    // Operand magnitude and result sign at acceptance time.
    always_comb begin
        a_mag_s = a_i;
        b_mag_s = b_i;
        neg_s   = 1'b0;
`ifdef MULT_SIGNED_EN
        a_mag_s = abs_a(a_i, signed_sel_s);
        b_mag_s = abs_b(b_i, signed_sel_s);
        if (signed_sel_s) begin
            neg_s = a_i[A_WIDTH-1] ^ b_i[B_WIDTH-1];
        end else begin
            neg_s = 1'b0;
        end
`else
        neg_s = signed_sel_s;
`endif
    end

    // One shift-add step and the sign-corrected final value.
    always_comb begin
        partial_s = P_ZERO;
        if (mplier_r[0]) begin
            partial_s = mcand_r;
        end else begin
            partial_s = P_ZERO;
        end
        acc_next_s = acc_r + partial_s;
        result_s   = acc_next_s;
`ifdef MULT_SIGNED_EN
        if (neg_r) begin
            result_s = neg_p(acc_next_s);
        end else begin
            result_s = acc_next_s;
        end
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            mcand_r   <= P_ZERO;
            mplier_r  <= {B_WIDTH{1'b0}};
            acc_r     <= P_ZERO;
            cnt_r     <= {CNT_W{1'b0}};
            neg_r     <= 1'b0;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            product_r <= P_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        mcand_r  <= {{B_WIDTH{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        acc_r    <= P_ZERO;
                        cnt_r    <= CNT_LOAD;
                        neg_r    <= neg_s;
                        ready_r  <= 1'b0;
                        state_r  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        product_r <= result_s;
                        valid_r   <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_r;
    assign valid_o   = valid_r;
    assign product_o = product_r;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: driver pushes expected products, a negedge monitor pops and checks
// value and latency whenever a result appears. A second 12x5 instance covers non-default widths.
module tb_seq_mult;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_i, ready_i, signed_i;
    logic [7:0]  a_i, b_i;
    logic        ready_o, valid_o;
    logic [15:0] product_o;

    logic        valid2_i;
    logic [11:0] a2_i;
    logic [4:0]  b2_i;
    logic        ready2_o, valid2_o;
    logic [16:0] product2_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
    } exp_t;
    exp_t sb_q[$];

    seq_mult #(.A_WIDTH(8), .B_WIDTH(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .valid_o(valid_o),
        .ready_i(ready_i), .product_o(product_o)
    );

    seq_mult #(.A_WIDTH(12), .B_WIDTH(5)) u_dut12 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid2_i), .ready_o(ready2_o),
        .a_i(a2_i), .b_i(b2_i), .signed_i(1'b0), .valid_o(valid2_o),
        .ready_i(1'b1), .product_o(product2_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a rising valid_o is one presented result.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid_o && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%0h with no pending operation", product_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("product", 32'(product_o), 32'(e.prod));
                check("latency", 32'(cyc - e.acc_cyc), 32'd8);
            end
        end
        prev_valid = valid_o;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!valid_o) check("valid_timeout", 32'(valid_o), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input bit push);
        wait_ready();
        a_i = a; b_i = b; signed_i = s; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        if (push) sb_q.push_back('{prod: exp, acc_cyc: cyc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; signed_i = 1'b0;
        a_i = 8'd0; b_i = 8'd0; valid2_i = 1'b0; a2_i = 12'd0; b2_i = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_product", 32'(product_o), 32'd0);
        check("rst_ready12", 32'(ready2_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned product with exact latency and one-cycle valid
        issue(8'd200, 8'd150, 1'b0, 16'h7530, 1'b1);
        check("ready_low_calc", 32'(ready_o), 32'd0);
        repeat (7) @(negedge clk);
        check("valid_not_early", 32'(valid_o), 32'd0);
        @(negedge clk);
        check("valid_rise", 32'(valid_o), 32'd1);
        check("ready_low_done", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("valid_one_cycle", 32'(valid_o), 32'd0);
        check("ready_back", 32'(ready_o), 32'd1);

        // Corners
        issue(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
        wait_valid(); @(negedge clk);
        issue(8'd0, 8'd200, 1'b0, 16'h0000, 1'b1);
        wait_valid(); @(negedge clk);

        // Signed-mode requests; unsigned results when sign logic is not built in
`ifdef MULT_SIGNED_EN
        issue(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
        wait_valid(); @(negedge clk);
        issue(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        wait_valid(); @(negedge clk);
`else
        issue(8'hFD, 8'h05, 1'b1, 16'h04F1, 1'b1);
        wait_valid(); @(negedge clk);
        issue(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        wait_valid(); @(negedge clk);
`endif
        issue(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
        wait_valid(); @(negedge clk);

        // Backpressure: result held, inputs ignored
        ready_i = 1'b0;
        issue(8'd7, 8'd9, 1'b0, 16'd63, 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            a_i = 8'($urandom); b_i = 8'($urandom); valid_i = ~valid_i;
            @(negedge clk);
            check("bp_valid", 32'(valid_o), 32'd1);
            check("bp_ready", 32'(ready_o), 32'd0);
            check("bp_product", 32'(product_o), 32'd63);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(valid_o), 32'd0);
        check("bp_release_ready", 32'(ready_o), 32'd1);
        check("bp_hold_product", 32'(product_o), 32'd63);

        // Asynchronous reset mid-calculation discards the operation
        issue(8'd100, 8'd3, 1'b0, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready_o), 32'd1);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_product", 32'(product_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(8'd12, 8'd11, 1'b0, 16'h0084, 1'b1);
        wait_valid(); @(negedge clk);

        // 12x5 instance: 4095 * 31 = 126945
        a2_i = 12'd4095; b2_i = 5'd31; valid2_i = 1'b1;
        @(negedge clk);
        valid2_i = 1'b0;
        k = cyc;
        for (int n = 0; n < 50 && !valid2_o; n++) @(negedge clk);
        check("w12_latency", 32'(cyc - k), 32'd5);
        check("w12_product", 32'(product2_o), 32'h1EFE1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
